// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: base opcodes, the bubble encoding and immediate formats.
// Used by the IF/ID stage and by the later execute stage.
package riscv_pkg;

    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
        case (opc)
            OP_IMM, LOAD, JALR: return IMM_I;
            STORE:              return IMM_S;
            BRANCH:             return IMM_B;
            LUI, AUIPC:         return IMM_U;
            JAL:                return IMM_J;
            default:            return IMM_NONE;
        endcase
    endfunction

    function automatic logic is_rv32i_op(input logic [6:0] opc);
        case (opc)
            OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC,
            JAL, OP, SYSTEM, MISC_MEM: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects the format from the opcode and
// returns the sign-extended immediate (0 for formats without one).
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm
);

    imm_fmt_e fmt;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        fmt = imm_fmt(instr[6:0]);
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with RV32I field decode; flush > stall > load.
// Optional stall/flush performance counters are built when IF_ID_PERF_CNT_EN is defined.
module if_id_stage #(
    parameter int          word_size = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic [word_size-1:0] pc_plus4_in,
    input  logic                 stall,
    input  logic                 flush,
    output logic [word_size-1:0] instr_out,
    output logic [word_size-1:0] pc_plus4_out,
    output logic [word_size-1:0] pc_out,
    output logic                 valid,
    output logic [6:0]           opcode,
    output logic [4:0]           rd,
    output logic [2:0]           funct3,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [6:0]           funct7,
    output logic [word_size-1:0] imm,
    output logic                 illegal,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);

    import riscv_pkg::*;

    logic load;
    assign load = ~stall | flush;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_out    <= NOP_INSTR;
            pc_plus4_out <= '0;
            valid        <= 1'b0;
        end else if (load) begin
            instr_out    <= flush ? NOP_INSTR : instruction;
            pc_plus4_out <= pc_plus4_in;
            valid        <= ~flush;
        end
    end

    assign pc_out = pc_plus4_out - word_size'(4);

    assign opcode = instr_out[6:0];
    assign rd     = instr_out[11:7];
    assign funct3 = instr_out[14:12];
    assign rs1    = instr_out[19:15];
    assign rs2    = instr_out[24:20];
    assign funct7 = instr_out[31:25];

    imm_gen u_imm_gen (
        .instr (instr_out),
        .imm   (imm)
    );

    assign illegal = valid & ~is_rv32i_op(opcode);

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Both counters saturate instead of wrapping so long runs never read as short ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (flush && (flush_q != '1))
                flush_q <= flush_q + 32'd1;
            if (stall && !flush && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues hand-computed expectations per
// clock, and an independent monitor pops and compares them on each falling edge.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] pc_plus4_in;
    logic        stall;
    logic        flush;
    logic [31:0] instr_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] pc_out;
    logic        valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .pc_plus4_in  (pc_plus4_in),
        .stall        (stall),
        .flush        (flush),
        .instr_out    (instr_out),
        .pc_plus4_out (pc_plus4_out),
        .pc_out       (pc_out),
        .valid        (valid),
        .opcode       (opcode),
        .rd           (rd),
        .funct3       (funct3),
        .rs1          (rs1),
        .rs2          (rs2),
        .funct7       (funct7),
        .imm          (imm),
        .illegal      (illegal),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        valid;
        logic [31:0] imm;
        logic        illegal;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   stim_done = 1'b0;
    logic [31:0] model_scnt = '0;
    logic [31:0] model_fcnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Monitor: outputs are registered, so falling-edge sampling sees settled values.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".instr_out"},    instr_out,    e.instr);
                check({e.name, ".pc_plus4_out"}, pc_plus4_out, e.pc4);
                check({e.name, ".pc_out"},       pc_out,       e.pc);
                check({e.name, ".valid"},        32'(valid),   32'(e.valid));
                check({e.name, ".opcode"},       32'(opcode),  32'(e.instr[6:0]));
                check({e.name, ".rd"},           32'(rd),      32'(e.instr[11:7]));
                check({e.name, ".funct3"},       32'(funct3),  32'(e.instr[14:12]));
                check({e.name, ".rs1"},          32'(rs1),     32'(e.instr[19:15]));
                check({e.name, ".rs2"},          32'(rs2),     32'(e.instr[24:20]));
                check({e.name, ".funct7"},       32'(funct7),  32'(e.instr[31:25]));
                check({e.name, ".imm"},          imm,          e.imm);
                check({e.name, ".illegal"},      32'(illegal), 32'(e.illegal));
                check({e.name, ".stall_cnt"},    stall_cnt,    e.scnt);
                check({e.name, ".flush_cnt"},    flush_cnt,    e.fcnt);
            end
        end
    end

    // Drive one cycle of inputs just after the monitor's sample point and queue the
    // outputs expected after the following rising edge.
    task automatic step(input string name, input logic r, input logic [31:0] ins,
                        input logic [31:0] p4, input logic st, input logic fl,
                        input logic [31:0] e_instr, input logic [31:0] e_pc4,
                        input logic [31:0] e_pc, input logic e_valid,
                        input logic [31:0] e_imm, input logic e_ill);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; instruction = ins; pc_plus4_in = p4; stall = st; flush = fl;
`ifdef IF_ID_PERF_CNT_EN
        if (!r) begin
            model_scnt = '0;
            model_fcnt = '0;
        end else if (fl) begin
            model_fcnt = model_fcnt + 1;
        end else if (st) begin
            model_scnt = model_scnt + 1;
        end
`endif
        e.name = name; e.instr = e_instr; e.pc4 = e_pc4; e.pc = e_pc; e.valid = e_valid;
        e.imm = e_imm; e.illegal = e_ill; e.scnt = model_scnt; e.fcnt = model_fcnt;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        rst = 1'b0; instruction = 32'h0; pc_plus4_in = 32'h0; stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < 3; i++)
            step("reset", 0, 32'h00500093, 32'h40, 0, 0, NOP, 32'h0, 32'hFFFFFFFC, 0, 32'h0, 0);

        step("load_addi", 1, 32'h00500093, 32'h4, 0, 0, 32'h00500093, 32'h4, 32'h0, 1, 32'h5, 0);
        step("stall1", 1, 32'hDEADBEEF, 32'h8,  1, 0, 32'h00500093, 32'h4, 32'h0, 1, 32'h5, 0);
        step("stall2", 1, 32'hFFFFFFFF, 32'hC,  1, 0, 32'h00500093, 32'h4, 32'h0, 1, 32'h5, 0);
        step("stall3", 1, 32'h123450B7, 32'h10, 1, 0, 32'h00500093, 32'h4, 32'h0, 1, 32'h5, 0);
        step("flush_stall", 1, 32'h00112423, 32'h14, 1, 1, NOP, 32'h14, 32'h10, 0, 32'h0, 0);

        step("beq",   1, 32'hFE000EE3, 32'h18, 0, 0, 32'hFE000EE3, 32'h18, 32'h14, 1, 32'hFFFFFFFC, 0);
        step("jal",   1, 32'h800000EF, 32'h1C, 0, 0, 32'h800000EF, 32'h1C, 32'h18, 1, 32'hFFF00000, 0);
        step("lui",   1, 32'h123450B7, 32'h20, 0, 0, 32'h123450B7, 32'h20, 32'h1C, 1, 32'h12345000, 0);
        step("sw",    1, 32'h00112423, 32'h24, 0, 0, 32'h00112423, 32'h24, 32'h20, 1, 32'h00000008, 0);
        step("addi_neg", 1, 32'hFFF00093, 32'h28, 0, 0, 32'hFFF00093, 32'h28, 32'h24, 1, 32'hFFFFFFFF, 0);
        step("auipc", 1, 32'h00001117, 32'h2C, 0, 0, 32'h00001117, 32'h2C, 32'h28, 1, 32'h00001000, 0);
        step("ecall", 1, 32'h00000073, 32'h30, 0, 0, 32'h00000073, 32'h30, 32'h2C, 1, 32'h0, 0);

        step("illegal",       1, 32'hFFFFFFFF, 32'h34, 0, 0, 32'hFFFFFFFF, 32'h34, 32'h30, 1, 32'h0, 1);
        step("illegal_flush", 1, 32'hFFFFFFFF, 32'h38, 0, 1, NOP, 32'h38, 32'h34, 0, 32'h0, 0);
        step("pc_wrap",       1, 32'h00000033, 32'h0,  0, 0, 32'h00000033, 32'h0, 32'hFFFFFFFC, 1, 32'h0, 0);

        step("stall4",        1, 32'h00500093, 32'h44, 1, 0, 32'h00000033, 32'h0, 32'hFFFFFFFC, 1, 32'h0, 0);
        step("reset_in_stall", 0, 32'h00500093, 32'h48, 1, 0, NOP, 32'h0, 32'hFFFFFFFC, 0, 32'h0, 0);
        step("resume",        1, 32'h00500093, 32'h4, 1, 1, NOP, 32'h4, 32'h0, 0, 32'h0, 0);
        step("reload",        1, 32'h00500093, 32'h8, 0, 0, 32'h00500093, 32'h8, 32'h4, 1, 32'h5, 0);

        stim_done = 1'b1;
    end

    initial begin
        int waited;
        wait (stim_done);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
